// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every handshake and memory-bus signal around the
// instruction/data memory arbiter.
//   master modport : the side outside the arbiter. It raises the fetch and
//                    data requests and supplies m_rdata (core plus memory).
//   slave modport  : the arbiter itself. It drives the grant, done and read
//                    data of each port, the memory strobes and busy.
// Parameters: AW address width, DW data width.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // fetch port
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_done;
    logic [DW-1:0] i_rdata;
    // data (load/store) port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    // shared single-port memory
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    // status
    logic          busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
        output m_req, m_we, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the core's
// instruction-fetch port and its data port. One access at a time goes
// through IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> DONE -> IDLE.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mem_arbiter_if.slave. It carries the fetch port (i_*), the data
//         port (d_*), the memory port (m_*) and busy.
// Parameters: AW, DW (these must match the interface), and MEM_LAT. MEM_LAT
// is the number of cycles from m_req to valid m_rdata and must be >= 1.
// Optional feature: define ARB_ROUND_ROBIN_EN to resolve conflicts in favour
// of the port that was not served last. When it is undefined, data always
// beats fetch.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;      // 1 = data port, 0 = fetch port
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          pick_d;                // the data port wins this IDLE cycle

`ifdef ARB_ROUND_ROBIN_EN
    logic          ptr_q, ptr_d;          // last served: 1 = data, 0 = fetch

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

    // On a conflict, the port that was not served last wins.
    always_comb begin
        pick_d = bus.d_req && (!bus.i_req || !ptr_q);
    end
`else
    always_comb begin
        pick_d = bus.d_req;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        bus.i_gnt   = 1'b0;
        bus.i_done  = 1'b0;
        bus.d_gnt   = 1'b0;
        bus.d_done  = 1'b0;
        bus.m_req   = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.i_rdata = i_rdata_q;
        bus.d_rdata = d_rdata_q;
        bus.busy    = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    owner_d = pick_d;
                    addr_d  = pick_d ? bus.d_addr : bus.i_addr;
                    we_d    = pick_d && bus.d_we;          // fetches never write
                    wdata_d = pick_d ? bus.d_wdata : '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                bus.m_req   = 1'b1;
                bus.m_we    = we_q;
                bus.m_addr  = addr_q;
                bus.m_wdata = wdata_q;
                bus.i_gnt   = !owner_q;
                bus.d_gnt   = owner_q;
                cnt_d       = CW'(MEM_LAT);
`ifdef ARB_ROUND_ROBIN_EN
                ptr_d       = owner_q;
`endif
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                // A count of 1 marks the cycle in which m_rdata is valid.
                if (cnt_q == CW'(1)) begin
                    if (!we_q) begin
                        if (owner_q) d_rdata_d = bus.m_rdata;
                        else         i_rdata_d = bus.m_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.i_done = !owner_q;
                bus.d_done = owner_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) bus4 ();

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    // Memory contents: 0x40 holds a fixed instruction word, and every other
    // address returns the address XOR 0xA5A5_0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2008_0005 : (a ^ 32'hA5A5_0000);
    endfunction

    // Memory models. The read word is valid only exactly MEM_LAT cycles after
    // m_req; in every other cycle the model returns filler that is tagged
    // with the age, so a mistimed capture is visible.
    int age1, age4;
    logic [31:0] maddr1, maddr4;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age1 <= 0; maddr1 <= '0; age4 <= 0; maddr4 <= '0;
        end else begin
            if (bus1.m_req) begin age1 <= 1; maddr1 <= bus1.m_addr; end
            else if (age1 != 0) age1 <= age1 + 1;
            if (bus4.m_req) begin age4 <= 1; maddr4 <= bus4.m_addr; end
            else if (age4 != 0) age4 <= age4 + 1;
        end
    end
    assign bus1.m_rdata = (age1 == 1) ? mem_word(maddr1) : (32'hBAD0_0000 | 32'(age1));
    assign bus4.m_rdata = (age4 == 4) ? mem_word(maddr4) : (32'hBAD0_0000 | 32'(age4));

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [134:0] o1, o4;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            o1 = {bus1.i_gnt, bus1.i_done, bus1.i_rdata, bus1.d_gnt, bus1.d_done, bus1.d_rdata,
                  bus1.m_req, bus1.m_we, bus1.m_addr, bus1.m_wdata, bus1.busy};
            o4 = {bus4.i_gnt, bus4.i_done, bus4.i_rdata, bus4.d_gnt, bus4.d_done, bus4.d_rdata,
                  bus4.m_req, bus4.m_we, bus4.m_addr, bus4.m_wdata, bus4.busy};
            checks++;
            if (o1 !== '0) begin
                failures++;
                $display("FAIL reset_idle_lat1 cycle=%0d outputs=%h required=0", k, o1);
            end
            checks++;
            if (o4 !== '0) begin
                failures++;
                $display("FAIL reset_idle_lat4 cycle=%0d outputs=%h required=0", k, o4);
            end
        end
        $display("reset: 10 idle cycles observed");
    endtask

    task automatic test_fetch();
        tick();
        bus1.i_addr = 32'h0000_0040;
        bus1.i_req  = 1'b1;
        tick();  // C1
        checks++;
        if ({bus1.i_gnt, bus1.m_req, bus1.m_we, bus1.d_gnt, bus1.busy} !== 5'b11001) begin
            failures++;
            $display("FAIL fetch_grant got=%b required=11001",
                     {bus1.i_gnt, bus1.m_req, bus1.m_we, bus1.d_gnt, bus1.busy});
        end
        checks++;
        if (bus1.m_addr !== 32'h40) begin
            failures++;
            $display("FAIL fetch_m_addr got=%h required=00000040", bus1.m_addr);
        end
        tick();  // C2
        checks++;
        if ({bus1.i_gnt, bus1.m_req, bus1.i_done} !== 3'b000) begin
            failures++;
            $display("FAIL fetch_wait got=%b required=000", {bus1.i_gnt, bus1.m_req, bus1.i_done});
        end
        tick();  // C3
        checks++;
        if ({bus1.i_done, bus1.d_done} !== 2'b10) begin
            failures++;
            $display("FAIL fetch_done got=%b required=10", {bus1.i_done, bus1.d_done});
        end
        checks++;
        if (bus1.i_rdata !== 32'h2008_0005) begin
            failures++;
            $display("FAIL fetch_rdata got=%h required=20080005", bus1.i_rdata);
        end
        $display("fetch: addr=00000040 rdata=%h", bus1.i_rdata);
        bus1.i_req = 1'b0;
        tick();  // C4
        checks++;
        if ({bus1.busy, bus1.i_done} !== 2'b00) begin
            failures++;
            $display("FAIL fetch_idle got=%b required=00", {bus1.busy, bus1.i_done});
        end
    endtask

    task automatic test_store();
        tick();
        bus1.d_addr  = 32'h80;
        bus1.d_wdata = 32'hDEAD_BEEF;
        bus1.d_we    = 1'b1;
        bus1.d_req   = 1'b1;
        tick();  // C1
        checks++;
        if ({bus1.d_gnt, bus1.m_req, bus1.m_we, bus1.m_addr, bus1.m_wdata} !== {3'b111, 32'h80, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL store_issue got=%b/%h/%h required=111/00000080/deadbeef",
                     {bus1.d_gnt, bus1.m_req, bus1.m_we}, bus1.m_addr, bus1.m_wdata);
        end
        tick();  // C2
        checks++;
        if (bus1.m_we !== 1'b0) begin
            failures++;
            $display("FAIL store_we_one_cycle got=%b required=0", bus1.m_we);
        end
        tick();  // C3
        checks++;
        if ({bus1.d_done, bus1.m_we} !== 2'b10) begin
            failures++;
            $display("FAIL store_done got=%b required=10", {bus1.d_done, bus1.m_we});
        end
        checks++;
        if (bus1.d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL store_rdata_kept got=%h required=00000000", bus1.d_rdata);
        end
        $display("store: addr=00000080 wdata=deadbeef d_rdata=%h", bus1.d_rdata);
        bus1.d_req = 1'b0;
        bus1.d_we  = 1'b0;
        tick();  // C4
    endtask

    task automatic test_conflict();
        reset_pulse();
        checks++;
        if (bus1.i_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_clears_rdata got=%h required=00000000", bus1.i_rdata);
        end
        bus1.i_addr = 32'h44;
        bus1.d_addr = 32'h100;
        bus1.d_we   = 1'b0;
        bus1.i_req  = 1'b1;
        bus1.d_req  = 1'b1;
        tick();  // C1
        checks++;
        if ({bus1.d_gnt, bus1.i_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL conflict_first_grant got=%b required=10", {bus1.d_gnt, bus1.i_gnt});
        end
        tick();  // C2
        tick();  // C3
        checks++;
        if ({bus1.d_done, bus1.d_rdata} !== {1'b1, 32'hA5A5_0100}) begin
            failures++;
            $display("FAIL conflict_load got=%b/%h required=1/a5a50100", bus1.d_done, bus1.d_rdata);
        end
        $display("conflict: load addr=00000100 rdata=%h", bus1.d_rdata);
        bus1.d_req = 1'b0;
        tick();  // C4
        checks++;
        if (bus1.i_gnt !== 1'b0) begin
            failures++;
            $display("FAIL conflict_idle_gap got=%b required=0", bus1.i_gnt);
        end
        tick();  // C5
        checks++;
        if ({bus1.i_gnt, bus1.m_addr} !== {1'b1, 32'h44}) begin
            failures++;
            $display("FAIL conflict_second_grant got=%b/%h required=1/00000044", bus1.i_gnt, bus1.m_addr);
        end
        tick();
        tick();  // C7
        checks++;
        if ({bus1.i_done, bus1.i_rdata} !== {1'b1, 32'hA5A5_0044}) begin
            failures++;
            $display("FAIL conflict_fetch got=%b/%h required=1/a5a50044", bus1.i_done, bus1.i_rdata);
        end
        $display("conflict: fetch addr=00000044 rdata=%h", bus1.i_rdata);
        bus1.i_req = 1'b0;
        tick();
    endtask

    task automatic test_both_held();
        logic [3:0] seq = 4'b0;
        logic [3:0] exp_seq;
        int ng = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = 4'b0101;  // d, i, d, i (bit 0 is the first grant)
`else
        exp_seq = 4'b1111;  // data starves fetch
`endif
        reset_pulse();
        bus1.i_addr = 32'h48;
        bus1.d_addr = 32'h104;
        bus1.i_req  = 1'b1;
        bus1.d_req  = 1'b1;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (bus1.d_gnt) begin seq[ng] = 1'b1; ng++; end
            else if (bus1.i_gnt) begin seq[ng] = 1'b0; ng++; end
        end
        checks++;
        if (ng !== 4) begin
            failures++;
            $display("FAIL both_held_grant_count got=%0d required=4", ng);
        end
        checks++;
        if (seq !== exp_seq) begin
            failures++;
            $display("FAIL both_held_order got=%b required=%b", seq, exp_seq);
        end
        $display("both_held: grant order (1=data, lsb first) %b", seq);
        bus1.i_req = 1'b0;
        bus1.d_req = 1'b0;
        for (int c = 0; c < 20 && bus1.busy; c++) tick();
        reset_pulse();
    endtask

    task automatic test_lat4_load();
        int done_at = -1;
        tick();
        bus4.d_addr = 32'h200;
        bus4.d_we   = 1'b0;
        bus4.d_req  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                checks++;
                if ({bus4.d_gnt, bus4.m_req} !== 2'b11) begin
                    failures++;
                    $display("FAIL lat4_grant got=%b required=11", {bus4.d_gnt, bus4.m_req});
                end
            end
            if (bus4.d_done && done_at < 0) begin
                done_at = k;
                checks++;
                if (bus4.d_rdata !== 32'hA5A5_0200) begin
                    failures++;
                    $display("FAIL lat4_rdata got=%h required=a5a50200", bus4.d_rdata);
                end
                bus4.d_req = 1'b0;
            end
        end
        checks++;
        if (done_at !== 6) begin
            failures++;
            $display("FAIL lat4_done_cycle got=%0d required=6", done_at);
        end
        $display("lat4 load: addr=00000200 rdata=%h done_at=%0d", bus4.d_rdata, done_at);
        bus4.d_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int done_at = -1;
        logic saw_done = 1'b0;
        tick();
        bus4.i_addr = 32'h300;
        bus4.i_req  = 1'b1;
        tick();  // C1
        tick();  // C2
        tick();  // C3: WAIT
        rst = 1'b1;
        #1;
        checks++;
        if ({bus4.busy, bus4.m_req, bus4.i_gnt, bus4.i_done, bus4.d_gnt, bus4.d_done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%b required=000000",
                     {bus4.busy, bus4.m_req, bus4.i_gnt, bus4.i_done, bus4.d_gnt, bus4.d_done});
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            if (bus4.i_done || bus4.i_gnt) saw_done = 1'b1;
        end
        rst = 1'b0;
        checks++;
        if ({saw_done, bus4.i_gnt} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_no_pulse got=%b required=00", {saw_done, bus4.i_gnt});
        end
        tick();
        checks++;
        if ({bus4.i_gnt, bus4.m_addr} !== {1'b1, 32'h300}) begin
            failures++;
            $display("FAIL reset_mid_regrant got=%b/%h required=1/00000300", bus4.i_gnt, bus4.m_addr);
        end
        for (int k = 1; k <= 8 && done_at < 0; k++) begin
            tick();
            if (bus4.i_done) done_at = k;
        end
        checks++;
        if ({done_at == 5, bus4.i_rdata} !== {1'b1, 32'hA5A5_0300}) begin
            failures++;
            $display("FAIL reset_mid_complete done_after=%0d rdata=%h required=5/a5a50300", done_at, bus4.i_rdata);
        end
        $display("reset_mid: refetch addr=00000300 rdata=%h", bus4.i_rdata);
        bus4.i_req = 1'b0;
        tick();
    endtask

    initial begin
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0;  bus1.d_wdata = '0;
        bus4.i_req = 1'b0; bus4.i_addr = '0; bus4.d_req = 1'b0; bus4.d_we = 1'b0;
        bus4.d_addr = '0;  bus4.d_wdata = '0;
        test_reset();
        test_fetch();
        test_store();
        test_conflict();
        test_both_held();
        test_lat4_load();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port memory between the MIPS core's instruction-fetch port and its data (load/store) port. It sits between the core and a unified instruction/data memory. Each access is serialised through a small state machine that presents one request at a time to the memory, waits a fixed latency and returns a completion pulse to the winning requester. The core stalls on each port until that port's `done` pulse.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 1, cycles from `m_req` to valid `m_rdata` (must be ≥1)

- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `i_req` in 1: fetch request, held until `i_done`
- `i_addr` in AW: fetch address
- `i_gnt` out 1: fetch accepted (1-cycle pulse)
- `i_done` out 1: fetch complete (1-cycle pulse)
- `i_rdata` out DW: fetched word
- `d_req` in 1: data request, held until `d_done`
- `d_we` in 1: 1 = store, 0 = load
- `d_addr` in AW: data address
- `d_wdata` in DW: store data
- `d_gnt` out 1: data accepted (1-cycle pulse)
- `d_done` out 1: data access complete (1-cycle pulse)
- `d_rdata` out DW: loaded word
- `m_req` out 1: memory request strobe
- `m_we` out 1: memory write enable
- `m_addr` out AW: memory address
- `m_wdata` out DW: memory write data
- `m_rdata` in DW: memory read data
- `busy` out 1: state ≠ IDLE

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: if either request is active at the clock edge, latch the winner (`owner`), its address, `we` and `wdata`; go to ACCESS. Otherwise stay in IDLE.
- ACCESS (1 cycle):
  - drive `m_req`=1, `m_addr`/`m_wdata` from the latches;
  - drive `m_we` = latched `we` (always 0 for fetch);
  - pulse the owner's `gnt`;
  - load the wait counter with MEM_LAT; go to WAIT.
- WAIT (MEM_LAT cycles):
  - decrement the counter each cycle;
  - in the cycle where the counter = 1, register `m_rdata` into the owner's `rdata` (loads and fetches only; stores leave `d_rdata` unchanged);
  - go to DONE.
- DONE (1 cycle): pulse the owner's `done`; go to IDLE.
- Default arbitration is fixed priority: data beats fetch when both request in the same IDLE cycle.
- Requesters hold `req` and operands stable until `gnt`. Once latched, the access completes even if `req` drops.
- `i_rdata`/`d_rdata` hold their value until the next completing read on the same port.
- Counter width: `$clog2(MEM_LAT+1)`.

## Timing
- Request seen in IDLE at cycle C0: `gnt`/`m_req` in C1, `m_rdata` valid in C1+MEM_LAT, `done` and `rdata` valid in C2+MEM_LAT, IDLE in C3+MEM_LAT.
- Throughput: one access per MEM_LAT+3 cycles. There is no back-to-back issue: IDLE always lasts at least one cycle.
- Reset values: all outputs 0, `rdata` registers 0, state IDLE, counter 0, round-robin pointer = fetch.
- Reset asserted mid-access: the access is abandoned immediately, and no `gnt` or `done` follows. After reset deasserts, a still-held `req` is re-arbitrated from IDLE.
- A request arriving during ACCESS, WAIT or DONE waits for the next IDLE.
- Both requests held: they are served alternately only in round-robin mode. In fixed mode a continuous `d_req` starves fetch by design, because the core holds `d_req` only while stalled.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - a 1-bit last-served pointer, updated in ACCESS, selects the winner on conflicts;
  - the port not served last wins;
  - the pointer resets to fetch, so the first conflict grants data.
- Undefined: fixed data-over-fetch priority; the pointer logic is not built.

## Test plan
- Reset, then idle: all outputs 0, `busy`=0 for 10 cycles.
- Fetch only: `i_addr`=0x0000_0040, MEM_LAT=1, memory returns 0x2008_0005.
  - `i_gnt` and `m_req` one cycle after `req`;
  - `i_done` with `i_rdata`=0x2008_0005 three cycles after `req`.
- Store: `d_we`=1, `d_addr`=0x80, `d_wdata`=0xDEAD_BEEF.
  - `m_we`=1 with that address and data for exactly one cycle;
  - `d_done` pulses; `d_rdata` unchanged.
- Simultaneous `i_req` and `d_req`:
  - fixed mode: `d_gnt` first, then `i_gnt` MEM_LAT+3 cycles later;
  - `ARB_ROUND_ROBIN_EN` with both held: grants alternate d, i, d, i.
- MEM_LAT=4 load: `d_done` exactly 6 cycles after `d_req`; `d_rdata` equals `m_rdata` sampled 4 cycles after `m_req`.
- `rst` pulsed during WAIT: outputs 0 immediately, no `done`; the held request is re-granted 1 cycle after reset release.
